// File: rtl/pc_sequencer.sv
// Multicycle fetch/execute sequencer for the RV32I core: owns the PC, fetches
// one instruction, holds it through EXEC, and commits the next PC on retire.
module pc_sequencer #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic        instr_valid,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  input  logic        NextPCSrc,
  input  logic [31:0] ALURes,
  input  logic        stall,
  output logic        retired,
  output logic [31:0] retire_count,
  output logic        misaligned,
  output logic [1:0]  dbg_state
);

  // Fetch handshake: imem_req stays high for every FETCH cycle; a cycle with
  // imem_ack high completes the fetch and imem_rdata is captured on that edge.
  typedef enum logic [1:0] {
    S_RST   = 2'd0,
    S_FETCH = 2'd1,
    S_EXEC  = 2'd2,
    S_HALT  = 2'd3
  } state_t;

  state_t      state;
  logic [31:0] target;

  // JALR clears bit 0 of every target, so the same masking serves all branches.
  assign target    = {ALURes[31:1], 1'b0};
  assign imem_addr = pc;
  assign pc_plus4  = pc + 32'd4;
  assign dbg_state = state;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= S_RST;
      pc           <= RESET_PC;
      instr        <= NOP_INSTR;
      imem_req     <= 1'b0;
      instr_valid  <= 1'b0;
      retired      <= 1'b0;
      retire_count <= 32'd0;
      misaligned   <= 1'b0;
    end else begin
      retired <= 1'b0;
      case (state)
        S_RST: begin
          state    <= S_FETCH;
          imem_req <= 1'b1;
        end
        S_FETCH: begin
          if (imem_ack) begin
            state       <= S_EXEC;
            instr       <= imem_rdata;
            imem_req    <= 1'b0;
            instr_valid <= 1'b1;
          end
        end
        S_EXEC: begin
          if (!stall) begin
            retired      <= 1'b1;
            retire_count <= retire_count + 32'd1;
            instr_valid  <= 1'b0;
            if (NextPCSrc && target[1]) begin
              state      <= S_HALT;
              misaligned <= 1'b1;
            end else begin
              state    <= S_FETCH;
              imem_req <= 1'b1;
              pc       <= NextPCSrc ? target : pc_plus4;
            end
          end
        end
        S_HALT: begin
          state <= S_HALT;
        end
        default: begin
          state <= S_RST;
        end
      endcase
    end
  end

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Multicycle fetch/execute sequencer for the RV32I core. Owns the program counter, issues instruction-memory requests, holds the fetched instruction stable for one execute phase, and commits the next PC from the branch unit's `NextPCSrc` decision. It sits between instruction memory and the decode/ALU/branch-unit datapath, replacing the free-running PC register of the single-cycle build.

## Interface
- `RESET_PC`, 32'h0000_0000, PC value loaded on reset
- `NOP_INSTR`, 32'h0000_0013, instruction register value on reset (addi x0,x0,0)

- `clk` in 1: clock, all state on rising edge
- `rst` in 1: reset, asynchronous, active-high
- `imem_req` out 1: instruction fetch request, registered
- `imem_addr` out 32: fetch address, equals `pc`
- `imem_ack` in 1: memory returns `imem_rdata` valid this cycle
- `imem_rdata` in 32: fetched instruction word
- `instr` out 32: latched instruction, stable through EXEC
- `instr_valid` out 1: high while in EXEC
- `pc` out 32: address of `instr`
- `pc_plus4` out 32: `pc + 4`, modulo 2^32 (JAL/JALR link value)
- `NextPCSrc` in 1: branch unit decision, sampled in EXEC
- `ALURes` in 32: branch/jump target from ALU
- `stall` in 1: hold EXEC (e.g. data memory busy)
- `retired` out 1: one-cycle pulse when an instruction commits
- `retire_count` out 32: committed instruction count
- `misaligned` out 1: sticky fetch-misalignment fault

## Operation
- States: RST, FETCH, EXEC, HALT. Encoding is free.
- RST: entered asynchronously on `rst`. Moves to FETCH on the first clock edge after `rst` drops; `imem_req` is 0 during RST.
- FETCH: `imem_req`=1, `imem_addr`=`pc`. If `imem_ack`=1 at the edge, set `instr`<=`imem_rdata` and go to EXEC; otherwise stay.
- EXEC: `instr_valid`=1, `imem_req`=0. If `stall`=1, stay; `pc`, `instr`, and counters hold. If `stall`=0, commit:
  - Compute target as `{ALURes[31:1],1'b0}`. JALR bit-0 clear is applied unconditionally.
  - If `NextPCSrc`=0: `pc`<=`pc+4` and go to FETCH.
  - If `NextPCSrc`=1 and target[1]=0: `pc`<=target and go to FETCH.
  - If `NextPCSrc`=1 and target[1]=1: `pc` holds and go to HALT.
  - Every commit, including one that enters HALT, pulses `retired` and increments `retire_count`.
- HALT: `misaligned`=1, `imem_req`=0, `instr_valid`=0. Left only by `rst`.
- `imem_ack` is ignored outside FETCH.
- `imem_rdata` is sampled only on a FETCH edge with ack.
- Arithmetic: `pc+4` and `retire_count+1` wrap modulo 2^32. `pc` 32'hFFFF_FFFC advances to 32'h0000_0000.

## Timing
- Reset values: `pc`=RESET_PC, `instr`=NOP_INSTR, `imem_req`=0, `instr_valid`=0, `retired`=0, `retire_count`=0, `misaligned`=0.
- All outputs are registered or decoded from state only, with two exceptions combinational on registered `pc`: `imem_addr`, which is driven from `pc`, and `pc_plus4`, which is derived from `pc`.
- Best case is 2 cycles per instruction: one FETCH cycle with same-cycle ack, then one EXEC cycle.
- Each FETCH wait cycle and each stalled EXEC cycle adds one cycle.
- `retired` is high in the cycle after the committing edge, and for exactly one cycle.
- `retire_count` updates on the same edge.
- `NextPCSrc` and `ALURes` are sampled only at the committing EXEC edge. Changes during stall cycles have no effect.
- `rst` asserted mid-FETCH or mid-EXEC: all state returns to reset values immediately, without waiting for a clock. Any pending ack is dropped.
- `rst` and `imem_ack` high together: reset wins.

## Test plan
- Reset and sequential flow: release `rst`, ack every fetch in the same cycle.
  - Required: `imem_addr` sequence 0, 4, 8.
  - Required: `retired` pulses every 2nd cycle.
  - Required: `retire_count`=3 after the third EXEC.
- Taken branch: at `pc`=0x10, drive `NextPCSrc`=1 and `ALURes`=0x40.
  - Required: next `imem_addr`=0x40.
  - With `ALURes`=0x41 (JALR): next `imem_addr`=0x40.
- Wait and stall: delay `imem_ack` 3 cycles, then hold `stall`=1 for 2 EXEC cycles while toggling `NextPCSrc`. Release with `NextPCSrc`=0.
  - Required: `instr` stable throughout.
  - Required: single `retired` pulse.
  - Required: `pc` advances by 4.
  - Required: 7 cycles total for that instruction.
- Misaligned target: `NextPCSrc`=1, `ALURes`=0x22.
  - Required: HALT, with `misaligned`=1 and `imem_req`=0 indefinitely.
  - Required: `retire_count` incremented once.
  - Required: `rst` clears the fault.
- Wrap: start with `RESET_PC`=32'hFFFF_FFFC.
  - Required: `pc_plus4`=0.
  - Required: next fetch at 0.
- Async reset mid-FETCH: assert `rst` between clock edges while `imem_req`=1.
  - Required: `imem_req`=0 and `pc`=RESET_PC before the next edge.
  - Required: an ack arriving during reset is ignored.
